spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
Parametrised SPI mode-0 peripheral and register bank. It is the next generation of the fixed 5x8-bit write-only SPI control block. It samples sclk/ncs/copi into the clk domain, decodes {rw, address, data} frames, commits writes to NUM_REGS registers of DATA_W bits, and returns register contents on cipo for read frames. It sits between the chip's SPI pins and the output-enable/PWM control logic.

Parameters:
NUM_REGS, 5, number of registers; valid addresses 0..NUM_REGS-1.
DATA_W, 8, register and data-field width in bits.
ADDR_W, 7, address-field width in bits.
SYNC_STAGES, 2, synchroniser flops on sclk/ncs/copi before edge detection; minimum 2.

Ports:
clk  in  1  fast system clock; must be at least 4x sclk.
rst  in  1  asynchronous, active-high reset.
sclk  in  1  SPI clock, asynchronous to clk.
ncs  in  1  SPI chip select, active low.
copi  in  1  SPI controller-out data.
cipo  out  1  SPI controller-in data; 0 when not driving.
cipo_oe  out  1  high while driving cipo, for the pad tristate.
regs_out  out  NUM_REGS*DATA_W  flat register contents; reg k at bits [k*DATA_W +: DATA_W].
wr_strobe  out  NUM_REGS  one-cycle pulse on reg k when it commits.
frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset: regs_out=0, wr_strobe=0, frame_err=0, cipo=0, cipo_oe=0, FSM=IDLE, counters/shifters=0. Synchroniser flops reset to sclk=0, ncs=1, copi=0.
- Frame: FRAME_LEN = 1+ADDR_W+DATA_W bits, MSB-first. Bit0 = rw (1=write, 0=read), then address, then data. copi is sampled on the synchronised sclk rising edge, only while synchronised ncs=0.
- FSM states:
  - IDLE: enter CMD on the synchronised ncs falling edge; clears bit counter and shifters.
  - CMD: first rising edge captures rw; go to ADDR.
  - ADDR: ADDR_W rising edges shift in the address; after the last one, go to DATA.
  - DATA: DATA_W rising edges shift in data. After the last one, go to DONE.
  - DONE: any further rising edge moves to OVER.
  - OVER: absorbs extra rising edges.
- A synchronised ncs rising edge in any state returns to IDLE:
  - DONE + write + address<NUM_REGS: the register updates on the clk cycle after the ncs-rise detection; wr_strobe[addr] pulses that same cycle.
  - DONE + read: no register change, no pulse.
  - CMD/ADDR/DATA (short frame), OVER (long frame), or write with address>=NUM_REGS: no register change; frame_err pulses one cycle.
  - Read with address>=NUM_REGS is not an error; it returns zeros.
- Read data path:
  - On the ADDR->DATA transition with rw=0, load tx shifter with reg[addr] (0 if out of range).
  - cipo_oe rises and cipo = tx MSB on the next synchronised sclk falling edge; the tx shifter shifts left on each later falling edge.
  - cipo_oe falls and cipo returns to 0 on leaving DATA/DONE, or on ncs rise.
- Write/read ordering: a committed write is visible to a read that begins on the next frame.
- ncs falling edge while not IDLE (glitch) restarts the frame at CMD; the partial frame is dropped silently.
- Edge detection uses the last two synchroniser outputs. Edges and sample data come from the same stage, so copi is aligned with the sclk edge.
- Bit counter width is clog2(FRAME_LEN+2) and saturates; it never wraps.
- Reset mid-frame aborts everything; regs return to 0.

Optional Feature:
SPI_ERR_COUNT_EN:
- Defined: adds output err_count [7:0]. Reset 0; +1 on every frame_err pulse; saturates at 255.
- Also: address NUM_REGS becomes a read-only status address returning err_count zero-extended or truncated to DATA_W. Writes to it are discarded with frame_err. Any read of it clears err_count on the ncs rise of that frame, unless a new error lands the same cycle, in which case the result is 1.
- Undefined: no port, no status address; address NUM_REGS behaves as any out-of-range address.

Test Plan:
- Write 0x02=0xA5 (bits 1,0000010,10100101) -> regs_out[23:16]=0xA5 one clk after ncs-rise detection; wr_strobe=0b00100 for one cycle; other regs 0.
- Write 0x04=0x3C, then read 0x04 -> cipo shows 00111100 on the 8 data rising edges; cipo_oe high only during the data phase; regs unchanged by the read.
- Write to 0x05 (NUM_REGS=5) -> no reg change; frame_err one pulse; read 0x05 returns 0x00 without frame_err.
- Short frame (12 bits) and long frame (20 bits) of write 0x00=0xFF -> both discarded, reg0 stays 0, two frame_err pulses. A following valid 16-bit write then commits.
- Reset asserted mid-DATA phase after reg1 was 0x55 -> reg1=0, cipo_oe=0. The next full write 0x01=0x81 commits normally.
- With SPI_ERR_COUNT_EN: three bad frames, then read address 5 -> cipo returns 0x03; err_count=0 after ncs rise. Non-parametric build: NUM_REGS=16, DATA_W=16, ADDR_W=4 round-trip write/read of reg 15 = 0xBEEF.

Source files
------------

// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral with NUM_REGS x DATA_W read/write register bank
// Optional SPI_ERR_COUNT_EN: err_count output plus read-only status address at NUM_REGS.
module spi_reg_bank #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
`ifdef SPI_ERR_COUNT_EN
  ,
  output logic [7:0]                 err_count
`endif
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADDR_W + DATA_W);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, OVER} state_t;
  state_t state_q, state_d;

  // Index SYNC_STAGES-1 is the synchronised value; SYNC_STAGES is its previous sample.
  logic [SYNC_STAGES:0]   sclk_sync_q, ncs_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_full;
  logic [DATA_W-1:0] data_q, data_d, tx_q, tx_d, rd_val;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] strobe_q, strobe_d, wr_hit;
  logic              err_q, err_d;
`ifdef SPI_ERR_COUNT_EN
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              status_clr;
`endif

  logic copi_s, ncs_s, sclk_rise, sclk_fall, ncs_rise, ncs_fall;

  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign ncs_rise  = ncs_s & ~ncs_sync_q[SYNC_STAGES];
  assign ncs_fall  = ~ncs_s & ncs_sync_q[SYNC_STAGES];
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES] & ~ncs_s;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES] & ~ncs_s;
  assign addr_full = {addr_q[ADDR_W-2:0], copi_s};

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_full == ADDR_W'(k)) rd_val = regs_q[k];
    end
`ifdef SPI_ERR_COUNT_EN
    if (addr_full == ADDR_W'(NUM_REGS)) rd_val = DATA_W'(err_cnt_q);
`endif
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) wr_hit[k] = (addr_q == ADDR_W'(k));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    tx_d     = tx_q;
    oe_d     = oe_q;
    regs_d   = regs_q;
    strobe_d = '0;
    err_d    = 1'b0;
`ifdef SPI_ERR_COUNT_EN
    status_clr = 1'b0;
`endif
    if (ncs_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      case (state_q)
        DONE: begin
          if (rw_q) begin
            if (|wr_hit) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit[k]) regs_d[k] = data_q;
              end
              strobe_d = wr_hit;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CMD, ADDR, DATA, OVER: err_d = 1'b1;
        default: ;
      endcase
`ifdef SPI_ERR_COUNT_EN
      status_clr = !rw_q && (addr_q == ADDR_W'(NUM_REGS)) &&
                   (state_q == DATA || state_q == DONE || state_q == OVER);
`endif
    end else if (ncs_fall) begin
      state_d = CMD;
      cnt_d   = '0;
      rw_d    = 1'b0;
      addr_d  = '0;
      data_d  = '0;
      tx_d    = '0;
      oe_d    = 1'b0;
    end else if (sclk_rise) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
        CMD: begin
          rw_d    = copi_s;
          state_d = ADDR;
        end
        ADDR: begin
          addr_d = addr_full;
          if (cnt_q == ADDR_LAST) begin
            state_d = DATA;
            if (!rw_q) tx_d = rd_val;
          end
        end
        DATA: begin
          data_d = {data_q[DATA_W-2:0], copi_s};
          if (cnt_q == DATA_LAST) state_d = DONE;
        end
        DONE: begin
          state_d = OVER;
          oe_d    = 1'b0;
        end
        default: ;
      endcase
    end else if (sclk_fall && !rw_q && (state_q == DATA || state_q == DONE)) begin
      // First falling edge presents the MSB; later ones advance the shifter.
      if (oe_q) tx_d = {tx_q[DATA_W-2:0], 1'b0};
      else      oe_d = 1'b1;
    end
`ifdef SPI_ERR_COUNT_EN
    err_cnt_d = err_cnt_q;
    if (err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    if (status_clr) err_cnt_d = {7'd0, err_q};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      strobe_q    <= '0;
      err_q       <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
`ifdef SPI_ERR_COUNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], sclk};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-1:0], ncs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      oe_q        <= oe_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
      regs_q      <= regs_d;
`ifdef SPI_ERR_COUNT_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign cipo      = oe_q & tx_q[DATA_W-1];
  assign cipo_oe   = oe_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;
`ifdef SPI_ERR_COUNT_EN
  assign err_count = err_cnt_q;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench for spi_reg_bank
module tb_spi_reg_bank;
  localparam int NR = 5, DW = 8, AW = 7;
  localparam int FL = 1 + AW + DW;
  localparam int HALF = 5, GAP = 12;
  localparam int K_WR = 0, K_ERR = 1, K_RD = 2;
`ifdef SPI_ERR_COUNT_EN
  localparam bit HAS_ERR = 1'b1;
`else
  localparam bit HAS_ERR = 1'b0;
`endif

  logic clk = 1'b0, rst, sclk, ncs, copi;
  logic cipo, cipo_oe, frame_err;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0] wr_strobe;
`ifdef SPI_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  spi_reg_bank #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .frame_err(frame_err)
`ifdef SPI_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    logic [DW-1:0] data;
    logic [NR*DW-1:0] regs;
  } exp_t;

  exp_t q[$];
  logic [DW-1:0] mem [NR];
  int errcnt = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] v;
    for (int k = 0; k < NR; k++) v[k*DW +: DW] = mem[k];
    return v;
  endfunction

  task automatic push(input int kind, input int a, input logic [DW-1:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d; e.regs = flat();
    q.push_back(e);
  endtask

  task automatic push_err();
    push(K_ERR, 0, '0);
    errcnt = (errcnt < 255) ? errcnt + 1 : 255;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bits_out(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      copi = w[n-1-i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] w, input int n);
    ncs = 1'b0;
    wait_clk(HALF);
    bits_out(w, n);
    wait_clk(HALF);
    ncs = 1'b1;
    copi = 1'b0;
    wait_clk(GAP);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    if (a < NR) begin
      mem[a] = d;
      push(K_WR, a, d);
    end else begin
      push_err();
    end
    frame(32'({1'b1, AW'(a), d}), FL);
  endtask

  task automatic do_read(input int a);
    logic [DW-1:0] exp;
    if (a < NR) exp = mem[a];
    else if (HAS_ERR && a == NR) begin
      exp = DW'(errcnt);
      errcnt = 0;
    end else exp = '0;
    push(K_RD, a, exp);
    frame(32'({1'b0, AW'(a), DW'($urandom)}), FL);
  endtask

  task automatic do_bad(input int a, input logic [DW-1:0] d, input int n);
    logic [31:0] w;
    w = 32'({1'b1, AW'(a), d});
    if (n < FL) w = w >> (FL - n);
    else w = (w << (n - FL)) | 32'($urandom_range(0, (1 << (n - FL)) - 1));
    push_err();
    frame(w, n);
  endtask

  task automatic monitor();
    logic sclk_p, ncs_p;
    int rcnt;
    logic [DW-1:0] rbits;
    exp_t e;
    sclk_p = 1'b0; ncs_p = 1'b1; rcnt = 0; rbits = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ncs_p && !ncs) begin rcnt = 0; rbits = '0; end
        if (!sclk_p && sclk && !ncs && cipo_oe) begin
          rbits = {rbits[DW-2:0], cipo};
          rcnt++;
        end
        if (!ncs_p && ncs) begin
          if (q.size() > 0 && q[0].kind == K_RD) begin
            e = q.pop_front();
            chk($sformatf("rd_data[a=%0d]", e.addr), rbits, e.data);
            chk("rd_oe_bits", rcnt, DW);
            chk("rd_regs_unchanged", regs_out, e.regs);
          end else if (rcnt != 0) begin
            chk("oe_outside_read", rcnt, 0);
          end
        end
        if (wr_strobe != '0 || frame_err) begin
          if (q.size() == 0) chk("unexpected_event", {wr_strobe, frame_err}, 0);
          else begin
            e = q.pop_front();
            chk("event_kind", frame_err ? K_ERR : K_WR, e.kind);
            if (e.kind == K_WR) begin
              chk($sformatf("wr_strobe[a=%0d]", e.addr), wr_strobe, 64'd1 << e.addr);
              chk("wr_regs", regs_out, e.regs);
            end
          end
        end
      end
      sclk_p = sclk;
      ncs_p = ncs;
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    for (int k = 0; k < NR; k++) mem[k] = '0;
    fork
      monitor();
    join_none
    wait_clk(4);
    chk("rst_regs", regs_out, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cipo", {cipo, cipo_oe}, 0);
    rst = 1'b0;
    wait_clk(4);

    do_write(2, 8'hA5);
    do_write(4, 8'h3C);
    do_read(4);
    do_write(NR, 8'h77);
    do_read(NR + 1);
    do_bad(0, 8'hFF, 12);
    do_bad(0, 8'hFF, 20);
    do_read(0);
    do_write(0, 8'h11);
    do_write(1, 8'h55);

    // Abort a read of reg1 mid-data with reset.
    ncs = 1'b0;
    wait_clk(HALF);
    bits_out(32'({1'b0, AW'(1), 8'h00}), 12);
    wait_clk(HALF);
    chk("pre_rst_oe", cipo_oe, 1);
    rst = 1'b1;
    wait_clk(2);
    chk("midrst_regs", regs_out, 0);
    chk("midrst_oe", {cipo_oe, cipo}, 0);
    for (int k = 0; k < NR; k++) mem[k] = '0;
    errcnt = 0;
    ncs = 1'b1; copi = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(GAP);
    do_write(1, 8'h81);
    do_read(1);

`ifdef SPI_ERR_COUNT_EN
    do_write(NR + 2, 8'h01);
    do_bad(3, 8'h42, 9);
    do_write(NR, 8'h09);
    do_read(NR);
    chk("err_count_cleared", err_count, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) do_write($urandom_range(0, NR + 2), DW'($urandom));
      else if (r < 8) do_read($urandom_range(0, NR + 2));
      else if (r == 8) do_bad($urandom_range(0, NR - 1), DW'($urandom), $urandom_range(1, FL - 1));
      else do_bad($urandom_range(0, NR - 1), DW'($urandom), $urandom_range(FL + 1, FL + 6));
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_regs", regs_out, flat());
`ifdef SPI_ERR_COUNT_EN
    chk("final_err_count", err_count, errcnt);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
